// File: rtl/pc_clear_responder.sv
// pc_clear_responder
//
// Receives the CPU master-clear strobe, synchronises it into the core clock
// domain and detects its rising edge. Each detected edge starts the
// program-counter initialisation sequence:
//   CLEAR (CLR_CYCLES cycles) -> LOAD (1 cycle) -> WAIT_ACK -> RUN.
// A new edge in any state restarts the sequence from CLEAR.
//
// Ports:
//   clk        core clock, rising edge
//   reset      synchronous active-high reset
//   mc_in      master-clear strobe, may be asynchronous to clk
//   run_ack    control-unit acknowledge of cpu_ready
//   pc_clr     program-counter clear (high in CLEAR)
//   pc_load    one-cycle load strobe (high in LOAD)
//   pc_addr    START_ADDR while pc_load is high, 0 otherwise
//   cpu_ready  initialisation complete, waiting for run_ack
//   cpu_run    CPU released to run
//   busy       high in CLEAR, LOAD or WAIT_ACK
//   mc_count   saturating count of detected master-clear edges

module pc_clear_responder #(
  parameter int                CLR_CYCLES = 4,
  parameter int                ADDR_W     = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mc_in,
  input  logic              run_ack,
  output logic              pc_clr,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              cpu_ready,
  output logic              cpu_run,
  output logic              busy,
  output logic [CNT_W-1:0]  mc_count
);

  // Sized so the counter can hold CLR_CYCLES-1 for every legal CLR_CYCLES.
  localparam int CW = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    WAIT_ACK,
    RUN
  } state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [CW-1:0] clr_cnt;
  logic          mc_edge;

  // s1/s2 form the metastability synchroniser; s3 is the delayed copy used
  // for rising-edge detection, so a held-high strobe yields one edge.
  assign mc_edge = s2 & ~s3;

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others (the synchroniser chain
  // depends on this to shift by exactly one stage per clock).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= IDLE;
      clr_cnt  <= '0;
      mc_count <= '0;
    end else begin
      s1 <= mc_in;
      s2 <= s1;
      s3 <= s2;

      if (mc_edge) begin
        // A new strobe wins over everything, including run_ack in WAIT_ACK.
        state   <= CLEAR;
        clr_cnt <= CW'(CLR_CYCLES - 1);
        if (mc_count != '1)
          mc_count <= mc_count + 1'b1;
      end else begin
        case (state)
          CLEAR: begin
            if (clr_cnt == '0)
              state <= LOAD;
            else
              clr_cnt <= clr_cnt - 1'b1;
          end
          LOAD:     state <= WAIT_ACK;
          WAIT_ACK: if (run_ack) state <= RUN;
          default:  ;  // IDLE and RUN hold until the next edge
        endcase
      end
    end
  end

  // Outputs decode the state register only; no input reaches an output
  // without passing through a flop.
  assign pc_clr    = (state == CLEAR);
  assign pc_load   = (state == LOAD);
  assign cpu_ready = (state == WAIT_ACK);
  assign cpu_run   = (state == RUN);
  assign busy      = (state == CLEAR) || (state == LOAD) || (state == WAIT_ACK);
  assign pc_addr   = pc_load ? START_ADDR : '0;

endmodule

// File: tb/tb_pc_clear_responder.sv
// Testbench for pc_clear_responder.
// Two instances share the same stimulus: a CLR_CYCLES=4 / START_ADDR=4'hA
// build and a CLR_CYCLES=1 / START_ADDR=4'h5 build. A reference model
// describes the sequence as "cycles elapsed since the triggering edge" and
// pushes the expected outputs per cycle into a queue per instance; a separate
// monitor pops and compares after every rising clock edge.

module tb_pc_clear_responder;

  typedef struct packed {
    logic       clr;
    logic       load;
    logic [3:0] addr;
    logic       ready;
    logic       run;
    logic       busy;
    logic [3:0] count;
  } obs_t;

  logic clk;
  logic reset;
  logic mc_in;
  logic run_ack;

  logic       clr_a, load_a, ready_a, run_a, busy_a;
  logic [3:0] addr_a, count_a;
  logic       clr_b, load_b, ready_b, run_b, busy_b;
  logic [3:0] addr_b, count_b;

  pc_clear_responder #(
    .CLR_CYCLES(4), .ADDR_W(4), .START_ADDR(4'hA), .CNT_W(4)
  ) dut_a (
    .clk(clk), .reset(reset), .mc_in(mc_in), .run_ack(run_ack),
    .pc_clr(clr_a), .pc_load(load_a), .pc_addr(addr_a),
    .cpu_ready(ready_a), .cpu_run(run_a), .busy(busy_a), .mc_count(count_a)
  );

  pc_clear_responder #(
    .CLR_CYCLES(1), .ADDR_W(4), .START_ADDR(4'h5), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .mc_in(mc_in), .run_ack(run_ack),
    .pc_clr(clr_b), .pc_load(load_b), .pc_addr(addr_b),
    .cpu_ready(ready_b), .cpu_run(run_b), .busy(busy_b), .mc_count(count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  obs_t q_a[$];
  obs_t q_b[$];

  // ---------------- reference model ----------------
  // Per instance: the last three sampled mc_in values, whether a sequence
  // is active, how many cycles it has been active (t=0 is the first clear
  // cycle), whether the CPU has been released, and the edge count.
  int clr_len [2] = '{4, 1};
  int start_v [2] = '{10, 5};
  bit hist    [2][3];
  bit active  [2];
  int t_seq   [2];
  bit running [2];
  int edges   [2];

  task automatic model_step(input int d, input bit mc, input bit ack,
                            input bit rst, output obs_t o);
    bit e;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[d][k] = 1'b0;
      active[d]  = 1'b0;
      t_seq[d]   = 0;
      running[d] = 1'b0;
      edges[d]   = 0;
    end else begin
      // An edge is acted on when the sample two edges ago was high and the
      // one three edges ago was low.
      e = hist[d][1] && !hist[d][2];
      hist[d][2] = hist[d][1];
      hist[d][1] = hist[d][0];
      hist[d][0] = mc;
      if (e) begin
        active[d]  = 1'b1;
        t_seq[d]   = 0;
        running[d] = 1'b0;
        if (edges[d] < 15) edges[d] = edges[d] + 1;
      end else if (active[d]) begin
        if (t_seq[d] == clr_len[d] + 1) begin
          if (ack) begin
            active[d]  = 1'b0;
            running[d] = 1'b1;
          end
        end else begin
          t_seq[d] = t_seq[d] + 1;
        end
      end
    end
    o.clr   = active[d] && (t_seq[d] < clr_len[d]);
    o.load  = active[d] && (t_seq[d] == clr_len[d]);
    o.ready = active[d] && (t_seq[d] == clr_len[d] + 1);
    o.run   = running[d];
    o.busy  = active[d];
    o.addr  = o.load ? 4'(start_v[d]) : 4'h0;
    o.count = 4'(edges[d]);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_no, act, exp);
    end
  endtask

  // Monitor: compares one expected record per instance after every edge.
  initial begin
    obs_t exp_o;
    obs_t act_o;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        exp_o = q_a.pop_front();
        act_o = '{clr_a, load_a, addr_a, ready_a, run_a, busy_a, count_a};
        check("outs_clr4", 16'(act_o), 16'(exp_o));
      end
      if (q_b.size() > 0) begin
        exp_o = q_b.pop_front();
        act_o = '{clr_b, load_b, addr_b, ready_b, run_b, busy_b, count_b};
        check("outs_clr1", 16'(act_o), 16'(exp_o));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of inputs at the falling edge and queues the outputs
  // expected after the following rising edge.
  task automatic cyc(input bit mc, input bit ack, input bit rst);
    obs_t e;
    @(negedge clk);
    cyc_no++;
    mc_in   = mc;
    run_ack = ack;
    reset   = rst;
    model_step(0, mc, ack, rst, e);
    q_a.push_back(e);
    model_step(1, mc, ack, rst, e);
    q_b.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mc_in   = 1'b0;
    run_ack = 1'b0;
    reset   = 1'b1;

    repeat (3) cyc(1'b0, 1'b0, 1'b1);

    // Single strobe; run_ack pulsed in IDLE, through CLEAR and LOAD, then
    // a single acknowledge once waiting.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle(1);
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0);
    idle(3);

    // Strobe held high for 20 cycles: one sequence only.
    repeat (20) cyc(1'b1, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);

    // Re-trigger while clearing.
    cyc(1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);

    // Re-trigger edge arrives on the same clock as run_ack in WAIT_ACK.
    cyc(1'b1, 1'b0, 1'b0);
    idle(5);
    cyc(1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-CLEAR, then reset mid-WAIT_ACK.
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset released while mc_in is already high: one edge.
    cyc(1'b1, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    idle(6);
    cyc(1'b0, 1'b1, 1'b0);

    // 20 strobes: edge counter saturates at 15.
    repeat (20) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    idle(10);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);

    // Randomised traffic.
    repeat (400) begin
      cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 80) == 0));
    end
    idle(4);

    @(posedge clk);
    #2;
    check("queue_a_drained", 16'(q_a.size()), 16'd0);
    check("queue_b_drained", 16'(q_b.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
